alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters (e.g. execute stage, address generation, debug port).
- Each requester uses a valid/ready handshake. A round-robin grant picks one requester and drives its operands and selALU code onto the ALU.
- The ALU result is captured into a one-entry response register, tagged with the requester id.
- Sits between the requesters and the ALU instance in the single-processor datapath.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 2, width of the requester id tag; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQx32  operand A per requester.
- req_b  input  NREQx32  operand B per requester.
- req_sel  input  NREQx4  ALU op code per requester.
- req_shamnt  input  NREQx5  shift amount per requester.
- alu_a  output  32  to ALU A.
- alu_b  output  32  to ALU B.
- alu_sel  output  4  to ALU selALU.
- alu_shamnt  output  5  to ALU shamnt.
- alu_c  input  32  ALU result C, combinational.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  32  captured result.
- rsp_id  output  IDW  index of the requester that issued it.
- rsp_err  output  1  op code was illegal (> 4'b1001).

Behaviour:
- Reset (synchronous, active-high):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - Round-robin pointer = 0.
  - req_ready=0 during the reset cycle.
- State is the response register: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready. Drain and refill in the same cycle is allowed, giving full throughput.
- Grant when can_accept: the first asserted req_valid at or after the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 only for the winner; all other bits are 0.
  - If no request or !can_accept, req_ready=0.
- req_ready depends combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
- ALU drive:
  - With a grant, alu_* = winner's operands, sel and shamnt.
  - Otherwise alu_* = 0 and alu_sel = 4'b0000 (ADD), so the bus does not toggle.
- Capture on the clock edge with a grant:
  - rsp_data <= alu_c, rsp_id <= g, rsp_valid <= 1.
  - Latency: accepted at cycle N, rsp_valid at N+1.
- Illegal op (req_sel > 4'b1001):
  - The request is still accepted; alu_sel is forced to 4'b0000.
  - The bench does not check alu_c in this case.
  - rsp_data <= 0, rsp_err <= 1. Otherwise rsp_err <= 0.
- Pointer update: after a grant, pointer <= (g+1) mod NREQ. No grant, no change.
- Drain without refill (rsp_valid & rsp_ready, no grant): rsp_valid <= 0. rsp_data, rsp_id and rsp_err hold their values.
- Backpressure (rsp_valid & !rsp_ready): the response register is frozen, all req_ready=0, and the pointer holds.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 next cycle) and the pointer returns to 0.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_e, 4-bit enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - Constant ALU_OP_MAX = 4'b1001.
  - Struct alu_req_t {a, b, sel, shamnt}.
- Sub-module rr_arbiter: parameter NREQ; inputs req, pointer, enable; outputs one-hot grant and encoded index. Purely combinational, reusable for the register-file port arbiter.

Test Plan:
- Single request: req_valid=01, a=5, b=3, sel=ADD, rsp_ready=1 -> req_ready=01 same cycle; next cycle rsp_valid=1, rsp_data=8, rsp_id=0, rsp_err=0.
- Contention, NREQ=2: both valid every cycle; req0 SUB 10-4, req1 XOR F0^0F; rsp_ready=1 -> grants alternate 0,1,0,1; responses 6 (id0), FF (id1) repeating.
- Backpressure: response FULL and rsp_ready=0 for 3 cycles with req1 valid -> req_ready=00 for 3 cycles, rsp_data stable; on rsp_ready=1, req1 is granted in the same cycle.
- Illegal op: sel=4'b1100 -> alu_sel=0000, accepted; next cycle rsp_err=1, rsp_data=0.
- Shift: sel=SLL, a=1, shamnt=31 -> rsp_data=32'h8000_0000. sel=SRL, a=32'h8000_0000, shamnt=4 -> 32'h0800_0000.
- Reset mid-operation: rst=1 while rsp_valid=1 and the pointer is 1 -> next cycle rsp_valid=0, all outputs 0; first post-reset contention grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, request record and response-register states.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9
    } alu_op_e;

    localparam logic [3:0] ALU_OP_MAX = 4'b1001;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  shamnt;
    } alu_req_t;

    // Response register occupancy.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Op codes above the last defined operation are rejected by the ALU.
    function automatic logic op_illegal(input logic [3:0] sel);
        return sel > ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// pointer wins, wrapping to the lowest index when nothing is at or above it.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  pointer,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index
);

    logic [NREQ-1:0] upper_mask;
    logic [NREQ-1:0] upper_req;
    logic [NREQ-1:0] pick;

    // Requesters at or above the pointer get first chance.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign upper_mask[gi] = (IDW'(gi) >= pointer);
        end
    endgenerate

    assign upper_req = req & upper_mask;

    // Lowest set bit of the upper half, else lowest set bit overall (the wrap).
    always_comb begin
        grant = '0;
        index = '0;
        pick  = (|upper_req) ? upper_req : req;
        if (enable) begin
            grant = pick & (~pick + NREQ'(1));
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (pick[i]) begin
                    index = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ valid/ready requesters and
// captures each result in a one-entry response register tagged with the
// requester id.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    input  logic [NREQ-1:0][3:0] req_sel,
    input  logic [NREQ-1:0][4:0] req_shamnt,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_sel,
    output logic [4:0]           alu_shamnt,
    input  logic [31:0]          alu_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err
);

    rsp_state_e     state_reg, state_next;
    logic [31:0]    data_reg, data_next;
    logic [IDW-1:0] id_reg, id_next;
    logic           err_reg, err_next;
    logic [IDW-1:0] ptr_reg, ptr_next;

    alu_req_t        reqs [NREQ];
    alu_req_t        win;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            can_accept;
    logic            illegal;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
            assign reqs[gi] = {req_a[gi], req_b[gi], req_sel[gi], req_shamnt[gi]};
        end
    endgenerate

    // Drain and refill in the same cycle keeps the ALU busy every cycle.
    assign can_accept = (state_reg == RSP_EMPTY) || rsp_ready;

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_arb (
        .req    (req_valid),
        .pointer(ptr_reg),
        .enable (can_accept && !rst),
        .grant  (grant),
        .index  (grant_idx)
    );

    assign grant_any = |grant;
    assign req_ready = grant;

    // One-hot AND-OR mux: an idle bus stays at all zeros (ADD, no toggling).
    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win = reqs[i];
            end
        end
    end

    assign illegal    = op_illegal(win.sel);
    assign alu_a      = win.a;
    assign alu_b      = win.b;
    assign alu_shamnt = win.shamnt;
    assign alu_sel    = illegal ? ADD : win.sel;

    // Response register next state: capture on grant, empty on drain, else hold.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        id_next    = id_reg;
        err_next   = err_reg;
        ptr_next   = ptr_reg;
        if (grant_any) begin
            state_next = RSP_FULL;
            data_next  = illegal ? 32'd0 : alu_c;
            id_next    = grant_idx;
            err_next   = illegal;
            ptr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (state_reg == RSP_FULL && rsp_ready) begin
            state_next = RSP_EMPTY;
        end
    end

    // State register with synchronous reset that also discards a pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RSP_EMPTY;
            data_reg  <= '0;
            id_reg    <= '0;
            err_reg   <= 1'b0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            id_reg    <= id_next;
            err_reg   <= err_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign rsp_valid = (state_reg == RSP_FULL);
    assign rsp_data  = data_reg;
    assign rsp_id    = id_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_alu_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_a;
    logic [NREQ-1:0][31:0] req_b;
    logic [NREQ-1:0][3:0]  req_sel;
    logic [NREQ-1:0][4:0]  req_shamnt;
    logic [31:0]           alu_a, alu_b, alu_c;
    logic [3:0]            alu_sel;
    logic [4:0]            alu_shamnt;
    logic                  rsp_valid, rsp_ready, rsp_err;
    logic [31:0]           rsp_data;
    logic [IDW-1:0]        rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .req_shamnt(req_shamnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_shamnt(alu_shamnt),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    // Behavioural ALU: the combinational unit the arbiter drives.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel, input logic [4:0] sh);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return {31'd0, $signed(a) < $signed(b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return 32'($signed(a) >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_c = alu_fn(alu_a, alu_b, alu_sel, alu_shamnt);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_sel    = '0;
        req_shamnt = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int          who;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  sh;
        logic [3:0]  exp_alu_sel;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    // Reference model state.
    logic            m_v;
    logic [31:0]     m_data;
    int              m_id;
    logic            m_err;
    int              m_ptr;

    initial begin
        int          g;
        int          c;
        logic [NREQ-1:0] exp_ready;
        logic [3:0]  exp_sel;

        vecs[0] = '{0, 32'd5,          32'd3,      4'd0,  5'd0,  4'd0, 32'd8,          1'b0};
        vecs[1] = '{1, 32'd1,          32'd0,      4'd2,  5'd31, 4'd2, 32'h8000_0000,  1'b0};
        vecs[2] = '{2, 32'h8000_0000,  32'd0,      4'd6,  5'd4,  4'd6, 32'h0800_0000,  1'b0};
        vecs[3] = '{0, 32'd7,          32'd9,      4'hC,  5'd0,  4'd0, 32'd0,          1'b1};
        vecs[4] = '{1, 32'd10,         32'd4,      4'd1,  5'd0,  4'd1, 32'd6,          1'b0};
        vecs[5] = '{2, 32'h8000_0000,  32'd0,      4'd7,  5'd4,  4'd7, 32'hF800_0000,  1'b0};
        vecs[6] = '{0, 32'hFFFF_FFFF,  32'd1,      4'd3,  5'd0,  4'd3, 32'd1,          1'b0};
        vecs[7] = '{1, 32'hFFFF_FFFF,  32'd1,      4'd4,  5'd0,  4'd4, 32'd0,          1'b0};
        vecs[8] = '{2, 32'h0000_F0F0,  32'hFF00,   4'd9,  5'd0,  4'd9, 32'h0000_F000,  1'b0};
        vecs[9] = '{0, 32'd1,          32'd2,      4'hF,  5'd3,  4'd0, 32'd0,          1'b1};

        // Reset: ready stays low even with every request valid.
        rst = 1'b1;
        clear_reqs();
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        clear_reqs();

        // Directed single-request vectors, back to back with rsp_ready=1.
        for (int i = 0; i < 10; i++) begin
            clear_reqs();
            req_valid[vecs[i].who]  = 1'b1;
            req_a[vecs[i].who]      = vecs[i].a;
            req_b[vecs[i].who]      = vecs[i].b;
            req_sel[vecs[i].who]    = vecs[i].sel;
            req_shamnt[vecs[i].who] = vecs[i].sh;
            #1;
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(1 << vecs[i].who));
            chk($sformatf("vec%0d_alu_sel", i), 32'(alu_sel), 32'(vecs[i].exp_alu_sel));
            tick();
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].who));
            chk($sformatf("vec%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            $display("[TB] vec %0d: req %0d sel %h -> data %h err %0d", i, vecs[i].who,
                     vecs[i].sel, rsp_data, rsp_err);
        end

        // Drain without refill: valid drops, payload holds.
        clear_reqs();
        #1;
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_sel", 32'(alu_sel), 32'd0);
        tick();
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("drain_rsp_err_hold", 32'(rsp_err), 32'd1);

        // Contention after reset: requesters 0 and 1 alternate.
        do_reset();
        req_valid = 3'b011;
        req_a[0] = 32'd10;  req_b[0] = 32'd4;  req_sel[0] = 4'd1;
        req_a[1] = 32'hF0;  req_b[1] = 32'h0F; req_sel[1] = 4'd5;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("cont%0d_req_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk($sformatf("cont%0d_rsp_id", k), 32'(rsp_id), 32'(k % 2));
            chk($sformatf("cont%0d_rsp_data", k), rsp_data, (k % 2 == 0) ? 32'd6 : 32'hFF);
            $display("[TB] contention %0d: id %0d data %h", k, rsp_id, rsp_data);
        end

        // Backpressure: full register, consumer stalls for 3 cycles.
        req_valid = 3'b010;
        req_a[1] = 32'd1; req_b[1] = 32'd2; req_sel[1] = 4'd0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_alu_a", k), alu_a, 32'd0);
            tick();
            chk($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rsp_data", k), rsp_data, 32'hFF);
            $display("[TB] backpressure %0d: data %h", k, rsp_data);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 32'(req_ready), 32'd2);
        tick();
        chk("bp_release_rsp_data", rsp_data, 32'd3);
        chk("bp_release_rsp_id", 32'(rsp_id), 32'd1);

        // Move pointer to 1 with a pending response, then reset mid-operation.
        clear_reqs();
        req_valid = 3'b001;
        req_a[0] = 32'd20; req_b[0] = 32'd22;
        #1;
        chk("pre_rst_req_ready", 32'(req_ready), 32'd1);
        tick();
        chk("pre_rst_rsp_data", rsp_data, 32'd42);
        rst = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'd1);
        tick();
        chk("post_rst_rsp_id", 32'(rsp_id), 32'd0);
        $display("[TB] reset mid-op: first grant id %0d", rsp_id);

        // Randomized traffic against the reference model.
        do_reset();
        m_v = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_ptr = 0;
        for (int t = 0; t < 400; t++) begin
            req_valid = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                req_a[r]      = $urandom;
                req_b[r]      = (($urandom & 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                req_sel[r]    = 4'($urandom);
                req_shamnt[r] = 5'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            g = -1;
            if (!m_v || rsp_ready) begin
                for (int i = 0; i < NREQ; i++) begin
                    c = (m_ptr + i) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
            exp_sel   = (g >= 0 && req_sel[g] <= 4'd9) ? req_sel[g] : 4'd0;
            #1;
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_alu_a", alu_a, (g >= 0) ? req_a[g] : 32'd0);
            chk("rnd_alu_b", alu_b, (g >= 0) ? req_b[g] : 32'd0);
            chk("rnd_alu_sel", 32'(alu_sel), 32'(exp_sel));
            chk("rnd_alu_shamnt", 32'(alu_shamnt), (g >= 0) ? 32'(req_shamnt[g]) : 32'd0);
            if (g >= 0) begin
                m_v    = 1'b1;
                m_err  = (req_sel[g] > 4'd9);
                m_data = m_err ? 32'd0 : alu_fn(req_a[g], req_b[g], req_sel[g], req_shamnt[g]);
                m_id   = g;
                m_ptr  = (g + 1) % NREQ;
            end else if (m_v && rsp_ready) begin
                m_v = 1'b0;
            end
            tick();
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_v));
            chk("rnd_rsp_data", rsp_data, m_data);
            chk("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rnd_rsp_err", 32'(rsp_err), 32'(m_err));
            if (t % 50 == 0)
                $display("[TB] random %0d: grant %0d valid %0d data %h id %0d", t, g, rsp_valid,
                         rsp_data, rsp_id);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
